seg_chase_sequencer: RTL and testbench
======================================

// Module: seg_chase_sequencer
// PURPOSE
// - Sequencing controller for the 7-segment PWM fade engine: decides which segment is relit and when, and paces the decay.
// - Holds step timer, pattern position, direction and pause; emits one-cycle load/fade strobes to the downstream fade datapath.
// - Sits between the io_in control pins and the per-segment brightness/PWM registers. Owns no brightness state itself.
// PARAMETERS
// - COUNTER_WIDTH       22  step timer width; step period = {speed, {COUNTER_WIDTH-3{1'b1}}} + 1 cycles
// - FADE_COUNTER_WIDTH  20  fade_tick period = 2**FADE_COUNTER_WIDTH cycles, free-running
// - NUM_SEGMENTS        7   segments a..g, bit i = segment i (a=0 ... g=6)
// PORTS
// - clk          in   1  single clock
// - reset_n      in   1  asynchronous, active-low reset
// - speed        in   3  step rate select, 0 = fastest
// - direction    in   1  1 = forward through pattern, 0 = backward
// - pattern_sel  in   2  0 figure-8, 1 circle, 2 vertical bounce, 3 all-on flash
// - pause        in   1  1 = freeze step timer and position
// - seg_load     out  7  one-cycle pulse: load full brightness into flagged segment(s)
// - seg_index    out  3  segment addressed by current position (held between steps)
// - step_strobe  out  1  one-cycle pulse coincident with every seg_load
// - fade_tick    out  1  one-cycle pulse: downstream halves every brightness
// BEHAVIOUR
// - Reset (async): all outputs 0; timer, fade counter, pos = 0; FSM = IDLE; input regs = 0.
// - speed/direction/pattern_sel/pause registered once (1 cycle latency) before use.
// - FSM IDLE -> RUN on first edge after reset release: issues seg_load for pos 0 of the registered pattern.
// - RUN: timer increments; when timer >= limit: timer <= 0, pos advances, seg_load/step_strobe pulse next cycle.
// - RUN -> PAUSED when pause_q=1: timer and pos hold, no seg_load; fade counter keeps running. PAUSED -> RUN on pause_q=0, timer resumes from held value.
// - Limit compare is >=: lowering speed below current timer value forces a step on the next cycle (no 2**N wrap).
// - Patterns (segment indices): 0 = a,b,g,e,d,c,g,f (len 8); 1 = a,b,c,d,e,f (len 6); 2 = a,g,d,g (len 4); 3 = all (len 1, seg_load = 7'h7F, seg_index = 0).
// - pos wraps modulo pattern length; forward: len-1 -> 0; backward: 0 -> len-1.
// - pattern_sel change: current period completes; at that step pos <= 0 (not advanced), new pattern's entry 0 loaded.
// - direction change: applied at next step, from current pos.
// - seg_load is one-hot except pattern 3; seg_index updated in same cycle as seg_load.
// - fade_tick and seg_load may coincide: both assert; downstream contract is decay first, load wins.
// - Reset asserted mid-step: all strobes drop immediately; restart behaves as fresh IDLE.
// STRUCTURE
// - Package seg_chase_pkg: SEG_A..SEG_G index constants, pattern length constants, FSM state encoding (IDLE, RUN, PAUSED).
// - Sub-module seg_pattern_rom: combinational (pattern_sel, pos) -> seg_index, seg_load mask, pattern length.
// - Top holds input regs, step timer, fade counter, pos register, FSM and output strobe regs.
// TESTING (COUNTER_WIDTH=6 -> period = 8*speed+8; FADE_COUNTER_WIDTH=4 -> fade_tick every 16)
// - Reset release, speed=0, dir=1, pattern=0 -> seg_load 01,02,40,10,08,04,40,20 (hex), one every 8 cycles, then wraps to 01.
// - At pos 0, dir=0 -> next step seg_index=5 (f), then 6 (g), 2 (c); pattern 1 backward from a -> f.
// - speed=7 (64-cycle period), switch to speed=0 at timer=40 -> step within 2 cycles, then 8-cycle period.
// - pattern 0->1 mid period -> no early step; at boundary seg_load=01 then 02,04,08,10,20,01.
// - pause=1 for 50 cycles -> no seg_load/step_strobe, fade_tick still every 16; release -> next step after remaining count.
// - pattern 3 -> seg_load=7F every step; reset_n low mid-run -> all outputs 0 same cycle, restart re-issues seg_load=01.

Source files
------------

// File: rtl/seg_chase_pkg.sv
// ============================================================================
// Module : seg_chase_pkg
// Brief  : Segment indices, pattern ids/lengths and FSM encoding for the
//          7-segment chase sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seg_chase_pkg;

    localparam logic [2:0] SEG_A = 3'd0;
    localparam logic [2:0] SEG_B = 3'd1;
    localparam logic [2:0] SEG_C = 3'd2;
    localparam logic [2:0] SEG_D = 3'd3;
    localparam logic [2:0] SEG_E = 3'd4;
    localparam logic [2:0] SEG_F = 3'd5;
    localparam logic [2:0] SEG_G = 3'd6;

    localparam logic [1:0] PAT_FIG8   = 2'd0;
    localparam logic [1:0] PAT_CIRCLE = 2'd1;
    localparam logic [1:0] PAT_BOUNCE = 2'd2;
    localparam logic [1:0] PAT_FLASH  = 2'd3;

    localparam logic [3:0] LEN_FIG8   = 4'd8;
    localparam logic [3:0] LEN_CIRCLE = 4'd6;
    localparam logic [3:0] LEN_BOUNCE = 4'd4;
    localparam logic [3:0] LEN_FLASH  = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    function automatic logic [3:0] pattern_len(input logic [1:0] pat);
        logic [3:0] len;
        case (pat)
            PAT_FIG8:   len = LEN_FIG8;
            PAT_CIRCLE: len = LEN_CIRCLE;
            PAT_BOUNCE: len = LEN_BOUNCE;
            default:    len = LEN_FLASH;
        endcase
        return len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_pattern_rom.sv
// ============================================================================
// Module : seg_pattern_rom
// Brief  : Combinational pattern table: (pattern, position) -> segment index,
//          load mask and pattern length.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seg_pattern_rom
    import seg_chase_pkg::*;
#(
    parameter int NUM_SEGMENTS = 7
) (
    input  logic [1:0]              pattern_sel,
    input  logic [2:0]              pos,
    output logic [2:0]              seg_index,
    output logic [NUM_SEGMENTS-1:0] seg_mask,
    output logic [3:0]              pat_len
);

    always_comb begin
        seg_index = SEG_A;
        case (pattern_sel)
            PAT_FIG8: begin
                case (pos)
                    3'd0:    seg_index = SEG_A;
                    3'd1:    seg_index = SEG_B;
                    3'd2:    seg_index = SEG_G;
                    3'd3:    seg_index = SEG_E;
                    3'd4:    seg_index = SEG_D;
                    3'd5:    seg_index = SEG_C;
                    3'd6:    seg_index = SEG_G;
                    default: seg_index = SEG_F;
                endcase
            end
            PAT_CIRCLE: begin
                case (pos)
                    3'd1:    seg_index = SEG_B;
                    3'd2:    seg_index = SEG_C;
                    3'd3:    seg_index = SEG_D;
                    3'd4:    seg_index = SEG_E;
                    3'd5:    seg_index = SEG_F;
                    default: seg_index = SEG_A;
                endcase
            end
            PAT_BOUNCE: begin
                case (pos)
                    3'd1:    seg_index = SEG_G;
                    3'd2:    seg_index = SEG_D;
                    3'd3:    seg_index = SEG_G;
                    default: seg_index = SEG_A;
                endcase
            end
            default: seg_index = SEG_A;
        endcase
    end

    // Flash lights every segment at once; all other patterns are one-hot.
    assign seg_mask = (pattern_sel == PAT_FLASH) ? {NUM_SEGMENTS{1'b1}}
                    : ({{(NUM_SEGMENTS-1){1'b0}}, 1'b1} << seg_index);

    assign pat_len = pattern_len(pattern_sel);

endmodule

`default_nettype wire

// File: rtl/seg_chase_sequencer.sv
// ============================================================================
// Module : seg_chase_sequencer
// Brief  : Step timer, pattern position, pause FSM and load/fade strobes for
//          the 7-segment PWM fade engine.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seg_chase_sequencer
    import seg_chase_pkg::*;
#(
    parameter int COUNTER_WIDTH      = 22,
    parameter int FADE_COUNTER_WIDTH = 20,
    parameter int NUM_SEGMENTS       = 7
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2:0]              speed,
    input  logic                    direction,
    input  logic [1:0]              pattern_sel,
    input  logic                    pause,
    output logic [NUM_SEGMENTS-1:0] seg_load,
    output logic [2:0]              seg_index,
    output logic                    step_strobe,
    output logic                    fade_tick
);

    state_t                        state_q, state_d;
    logic [2:0]                    speed_q, speed_d;
    logic                          dir_q, dir_d;
    logic [1:0]                    pattern_q, pattern_d;
    logic                          pause_q, pause_d;
    logic [1:0]                    cur_pat_q, cur_pat_d;
    logic [2:0]                    pos_q, pos_d;
    logic [COUNTER_WIDTH-1:0]      timer_q, timer_d;
    logic [FADE_COUNTER_WIDTH-1:0] fade_cnt_q, fade_cnt_d;
    logic                          strobe_q, strobe_d;
    logic                          fade_tick_q, fade_tick_d;

    logic [COUNTER_WIDTH-1:0]      w_limit;
    logic [2:0]                    w_rom_index;
    logic [NUM_SEGMENTS-1:0]       w_rom_mask;
    logic [3:0]                    w_rom_len;
    logic [2:0]                    w_last;
    logic [2:0]                    w_pos_fwd;
    logic [2:0]                    w_pos_bwd;

    // The ROM always reflects the live position, so seg_index is held
    // between steps and changes together with the load strobe.
    seg_pattern_rom #(
        .NUM_SEGMENTS (NUM_SEGMENTS)
    ) u_rom (
        .pattern_sel (cur_pat_q),
        .pos         (pos_q),
        .seg_index   (w_rom_index),
        .seg_mask    (w_rom_mask),
        .pat_len     (w_rom_len)
    );

    assign w_limit   = {speed_q, {(COUNTER_WIDTH-3){1'b1}}};
    assign w_last    = 3'(w_rom_len - 4'd1);
    assign w_pos_fwd = (pos_q == w_last) ? 3'd0 : pos_q + 3'd1;
    assign w_pos_bwd = (pos_q == 3'd0) ? w_last : pos_q - 3'd1;

    always_comb begin
        state_d     = state_q;
        speed_d     = speed;
        dir_d       = direction;
        pattern_d   = pattern_sel;
        pause_d     = pause;
        cur_pat_d   = cur_pat_q;
        pos_d       = pos_q;
        timer_d     = timer_q;
        strobe_d    = 1'b0;
        fade_cnt_d  = fade_cnt_q + 1'b1;
        fade_tick_d = &fade_cnt_q;

        case (state_q)
            ST_IDLE: begin
                state_d  = ST_RUN;
                strobe_d = 1'b1;
                timer_d  = '0;
                pos_d    = 3'd0;
            end
            ST_RUN, ST_PAUSED: begin
                state_d = pause_q ? ST_PAUSED : ST_RUN;
                // Leaving PAUSED counts on the same edge, so the timer
                // simply runs on every cycle where pause_q is low.
                if (!pause_q) begin
                    // >= rather than == so a speed drop below the current
                    // count steps at once instead of wrapping the timer.
                    if (timer_q >= w_limit) begin
                        timer_d  = '0;
                        strobe_d = 1'b1;
                        if (pattern_q != cur_pat_q) begin
                            cur_pat_d = pattern_q;
                            pos_d     = 3'd0;
                        end else begin
                            pos_d = dir_q ? w_pos_fwd : w_pos_bwd;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            speed_q     <= '0;
            dir_q       <= 1'b0;
            pattern_q   <= '0;
            pause_q     <= 1'b0;
            cur_pat_q   <= PAT_FIG8;
            pos_q       <= '0;
            timer_q     <= '0;
            fade_cnt_q  <= '0;
            strobe_q    <= 1'b0;
            fade_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            dir_q       <= dir_d;
            pattern_q   <= pattern_d;
            pause_q     <= pause_d;
            cur_pat_q   <= cur_pat_d;
            pos_q       <= pos_d;
            timer_q     <= timer_d;
            fade_cnt_q  <= fade_cnt_d;
            strobe_q    <= strobe_d;
            fade_tick_q <= fade_tick_d;
        end
    end

    assign seg_load    = strobe_q ? w_rom_mask : '0;
    assign seg_index   = w_rom_index;
    assign step_strobe = strobe_q;
    assign fade_tick   = fade_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_chase_sequencer.sv
// ============================================================================
// Module : tb_seg_chase_sequencer
// Brief  : Directed-then-random bench for seg_chase_sequencer against a
//          pattern-table reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_seg_chase_sequencer;

    localparam int CW  = 6;
    localparam int FCW = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] speed;
    logic       direction;
    logic [1:0] pattern_sel;
    logic       pause;
    logic [6:0] seg_load;
    logic [2:0] seg_index;
    logic       step_strobe;
    logic       fade_tick;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int seq [4][8] = '{'{0, 1, 6, 4, 3, 2, 6, 5},
                       '{0, 1, 2, 3, 4, 5, 0, 0},
                       '{0, 6, 3, 6, 0, 0, 0, 0},
                       '{0, 0, 0, 0, 0, 0, 0, 0}};
    int plen [4] = '{8, 6, 4, 1};
    bit m_started;
    int m_speed, m_dir, m_pat, m_pause;
    int m_timer, m_pos, m_cur, m_cycles;
    bit m_strobe, m_tick;

    always #5 clk = ~clk;

    seg_chase_sequencer #(
        .COUNTER_WIDTH      (CW),
        .FADE_COUNTER_WIDTH (FCW),
        .NUM_SEGMENTS       (7)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .speed       (speed),
        .direction   (direction),
        .pattern_sel (pattern_sel),
        .pause       (pause),
        .seg_load    (seg_load),
        .seg_index   (seg_index),
        .step_strobe (step_strobe),
        .fade_tick   (fade_tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_speed = 0; m_dir = 0; m_pat = 0; m_pause = 0;
        m_timer = 0; m_pos = 0; m_cur = 0; m_cycles = 0;
        m_strobe = 0; m_tick = 0;
    endtask

    // One clock edge of the sequencer, described from the pattern rules.
    task automatic model_edge();
        int limit;
        m_tick = ((m_cycles % 16) == 15);
        m_cycles++;
        m_strobe = 0;
        if (!m_started) begin
            m_started = 1;
            m_strobe  = 1;
            m_timer   = 0;
            m_pos     = 0;
        end else if (m_pause == 0) begin
            limit = 8 * m_speed + 7;
            if (m_timer >= limit) begin
                m_timer  = 0;
                m_strobe = 1;
                if (m_pat != m_cur) begin
                    m_cur = m_pat;
                    m_pos = 0;
                end else if (m_dir != 0) begin
                    m_pos = (m_pos + 1) % plen[m_cur];
                end else begin
                    m_pos = (m_pos + plen[m_cur] - 1) % plen[m_cur];
                end
            end else begin
                m_timer++;
            end
        end
        m_speed = int'(speed);
        m_dir   = int'(direction);
        m_pat   = int'(pattern_sel);
        m_pause = int'(pause);
    endtask

    task automatic compare_outputs();
        int idx;
        int exp_load;
        idx = seq[m_cur][m_pos];
        exp_load = !m_strobe ? 0 : (m_cur == 3 ? 32'h7F : (1 << idx));
        check("seg_load",    32'(seg_load),    32'(exp_load));
        check("seg_index",   32'(seg_index),   32'(idx));
        check("step_strobe", 32'(step_strobe), 32'(m_strobe));
        check("fade_tick",   32'(fade_tick),   32'(m_tick));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_load"},   32'(seg_load),    32'h0);
        check({tag, "_index"},  32'(seg_index),   32'h0);
        check({tag, "_strobe"}, 32'(step_strobe), 32'h0);
        check({tag, "_tick"},   32'(fade_tick),   32'h0);
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once.
    task automatic reset_mid();
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("in_rst");
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        reset_n = 1'b0;
        speed = 3'd0; direction = 1'b1; pattern_sel = 2'd0; pause = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Figure-8 forward at the fastest rate, past one full wrap.
        repeat (80) cycle();

        // Backward through figure-8, then circle backward.
        direction = 1'b0;
        repeat (40) cycle();
        pattern_sel = 2'd1;
        repeat (40) cycle();

        // Slow rate, then drop speed once the timer has run well past 8.
        speed = 3'd7;
        direction = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (m_timer == 40) break;
        end
        check("slow_timer_reached", 32'(m_timer), 32'd40);
        speed = 3'd0;
        repeat (30) cycle();

        // Pattern change in mid-period waits for the boundary.
        pattern_sel = 2'd0;
        repeat (3) cycle();
        pattern_sel = 2'd1;
        repeat (60) cycle();

        // Pause: no steps, fade keeps ticking.
        speed = 3'd2;
        repeat (10) cycle();
        pause = 1'b1;
        repeat (50) cycle();
        pause = 1'b0;
        repeat (40) cycle();

        // Flash pattern, then reset in the middle of a run.
        pattern_sel = 2'd3;
        speed = 3'd0;
        repeat (30) cycle();
        reset_mid();
        repeat (30) cycle();

        // Random input sequences held for random spans.
        for (int k = 0; k < 60; k++) begin
            speed       = 3'($urandom_range(0, 7));
            direction   = 1'($urandom_range(0, 1));
            pattern_sel = 2'($urandom_range(0, 3));
            pause       = ($urandom_range(0, 4) == 0);
            repeat ($urandom_range(1, 40)) cycle();
            if (k == 30) begin
                reset_mid();
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
